// File: rtl/map_pkg.sv
// Shared map geometry, state codes and blast directions for every block
// that reads or writes the block map memory.
package map_pkg;

    localparam int NUM_ROW       = 11;
    localparam int NUM_COL       = 19;
    localparam int MAP_MEM_WIDTH = 4;
    localparam int BLK_IND_WIDTH = $clog2(NUM_ROW * NUM_COL);

    typedef enum logic [MAP_MEM_WIDTH-1:0] {
        NO_BLK          = 4'd0,
        PERM_BLK        = 4'd1,
        DESTROYABLE_BLK = 4'd2,
        PLAYER          = 4'd3,
        ENEMY           = 4'd4,
        BOMB            = 4'd5,
        EXPLOSION       = 4'd6,
        POWER_UP        = 4'd7,
        BORDER          = 4'd8
    } map_state_e;

    // Declaration order is the arm walk order.
    typedef enum logic [1:0] {
        DIR_RIGHT,
        DIR_LEFT,
        DIR_DOWN,
        DIR_UP
    } blast_dir_e;

    function automatic logic [BLK_IND_WIDTH-1:0] blk_addr(input int row, input int col);
        return BLK_IND_WIDTH'(row * NUM_COL + col);
    endfunction

endpackage

// File: rtl/blast_buf.sv
// FIFO of burnt block addresses, replayed in push order when the
// explosion is cleared.
module blast_buf #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bomb_ctrl.sv
// Single-bomb map writer: places the bomb, waits the fuse, walks four blast
// arms through the map read port, holds the explosion, then clears it.
module bomb_ctrl
    import map_pkg::*;
#(
    parameter int RANGE      = 2,
    parameter int FUSE_TICKS = 180,
    parameter int EXPL_TICKS = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     place_req,
    input  logic [3:0]               place_row,
    input  logic [4:0]               place_col,
    input  logic                     tick,
    output logic [BLK_IND_WIDTH-1:0] rd_addr,
    input  logic [MAP_MEM_WIDTH-1:0] rd_data,
    output logic                     wr_en,
    output logic [BLK_IND_WIDTH-1:0] wr_addr,
    output logic [MAP_MEM_WIDTH-1:0] wr_data,
    output logic                     busy,
    output logic                     exploding,
    output logic                     done
);

    localparam int BUF_DEPTH = 1 + 4 * RANGE;
    localparam int MAX_TICKS = (FUSE_TICKS > EXPL_TICKS) ? FUSE_TICKS : EXPL_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int STEP_W    = $clog2(RANGE + 1);

    typedef enum logic [3:0] {
        IDLE, PLACE, FUSE, CENTER, ARM_RD, ARM_WAIT, ARM_EVAL, BURN, CLEAR
    } state_e;

    state_e                   state;
    logic [3:0]               cen_row;
    logic [4:0]               cen_col;
    blast_dir_e               dir;
    logic [STEP_W-1:0]        step;
    logic [CNT_W-1:0]         tick_cnt;
    int                       nxt_row;
    int                       nxt_col;
    logic                     off_grid;
    logic [BLK_IND_WIDTH-1:0] nxt_addr;
    logic                     place_ok;
    logic                     fuse_last;
    logic                     expl_last;
    logic                     end_arm;
    logic                     push;
    logic                     pop;
    logic [BLK_IND_WIDTH-1:0] buf_head;
    logic                     buf_empty;

    // NOTE: every variable gets its default first so no path infers a latch.
    always_comb begin
        nxt_row = int'(cen_row);
        nxt_col = int'(cen_col);
        unique case (dir)
            DIR_RIGHT: nxt_col = nxt_col + int'(step);
            DIR_LEFT:  nxt_col = nxt_col - int'(step);
            DIR_DOWN:  nxt_row = nxt_row + int'(step);
            DIR_UP:    nxt_row = nxt_row - int'(step);
        endcase
        off_grid = (nxt_row < 0) || (nxt_row >= NUM_ROW) || (nxt_col < 0) || (nxt_col >= NUM_COL);
        nxt_addr = blk_addr(nxt_row, nxt_col);
    end

    assign place_ok  = place_req && (int'(place_row) < NUM_ROW) && (int'(place_col) < NUM_COL);
    assign fuse_last = tick && (tick_cnt == CNT_W'(FUSE_TICKS - 1));
    assign expl_last = tick && (tick_cnt == CNT_W'(EXPL_TICKS - 1));
    assign end_arm   = (state == ARM_RD && off_grid) ||
                       (state == ARM_EVAL && (rd_data == PERM_BLK || rd_data == DESTROYABLE_BLK ||
                                              step == STEP_W'(RANGE)));
    // Every explosion write is logged so the clear pass can replay it in order.
    assign push      = wr_en && (wr_data == EXPLOSION);
    assign pop       = (state == BURN && expl_last) || (state == CLEAR && !buf_empty);

    blast_buf #(
        .DEPTH(BUF_DEPTH),
        .WIDTH(BLK_IND_WIDTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (wr_addr),
        .dout (buf_head),
        .empty(buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cen_row   <= '0;
            cen_col   <= '0;
            dir       <= DIR_RIGHT;
            step      <= '0;
            tick_cnt  <= '0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            exploding <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: if (place_ok) begin
                    cen_row <= place_row;
                    cen_col <= place_col;
                    wr_en   <= 1'b1;
                    wr_addr <= blk_addr(int'(place_row), int'(place_col));
                    wr_data <= BOMB;
                    busy    <= 1'b1;
                    state   <= PLACE;
                end
                PLACE: begin
                    tick_cnt <= '0;
                    state    <= FUSE;
                end
                FUSE: if (fuse_last) begin
                    tick_cnt <= '0;
                    wr_en    <= 1'b1;
                    wr_addr  <= blk_addr(int'(cen_row), int'(cen_col));
                    wr_data  <= EXPLOSION;
                    state    <= CENTER;
                end else if (tick) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
                CENTER: begin
                    dir   <= DIR_RIGHT;
                    step  <= STEP_W'(1);
                    state <= ARM_RD;
                end
                ARM_RD: if (!off_grid) begin
                    rd_addr <= nxt_addr;
                    state   <= ARM_WAIT;
                end
                ARM_WAIT: state <= ARM_EVAL;
                ARM_EVAL: begin
                    if (rd_data != PERM_BLK) begin
                        wr_en   <= 1'b1;
                        wr_addr <= rd_addr;
                        wr_data <= EXPLOSION;
                    end
                    if (!end_arm) begin
                        step  <= step + 1'b1;
                        state <= ARM_RD;
                    end
                end
                BURN: if (expl_last) begin
                    wr_en   <= 1'b1;
                    wr_addr <= buf_head;
                    wr_data <= NO_BLK;
                    state   <= CLEAR;
                end else if (tick) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
                CLEAR: if (!buf_empty) begin
                    wr_en   <= 1'b1;
                    wr_addr <= buf_head;
                    wr_data <= NO_BLK;
                end else begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    exploding <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Closing an arm either moves to the next direction or, after up, into the burn.
            if (end_arm) begin
                if (dir == DIR_UP) begin
                    tick_cnt  <= '0;
                    exploding <= 1'b1;
                    state     <= BURN;
                end else begin
                    dir   <= blast_dir_e'(dir + 1'b1);
                    step  <= STEP_W'(1);
                    state <= ARM_RD;
                end
            end
        end
    end

endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed bench for bomb_ctrl: stimulus queues expected map writes and done
// pulses; a negedge monitor pops and compares them against DUT activity.
module tb_bomb_ctrl;
    import map_pkg::*;

    localparam int RANGE  = 2;
    localparam int FUSE_T = 3;
    localparam int EXPL_T = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     place_req = 1'b0;
    logic [3:0]               place_row = '0;
    logic [4:0]               place_col = '0;
    logic                     tick = 1'b0;
    logic [BLK_IND_WIDTH-1:0] rd_addr;
    logic [MAP_MEM_WIDTH-1:0] rd_data;
    logic                     wr_en;
    logic [BLK_IND_WIDTH-1:0] wr_addr;
    logic [MAP_MEM_WIDTH-1:0] wr_data;
    logic                     busy;
    logic                     exploding;
    logic                     done;

    bomb_ctrl #(
        .RANGE     (RANGE),
        .FUSE_TICKS(FUSE_T),
        .EXPL_TICKS(EXPL_T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .place_req(place_req),
        .place_row(place_row),
        .place_col(place_col),
        .tick     (tick),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .exploding(exploding),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [NUM_ROW * NUM_COL];

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    typedef struct packed {
        logic       is_done;
        logic [7:0] addr;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cells[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   writes_seen = 0;
    int   base_writes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {19'b0, 1'b0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_item", {19'b0, 1'b0, wr_addr, wr_data}, {19'b0, mon_e});
            end
        end
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'h1000, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_item", {19'b0, 13'h1000}, {19'b0, mon_e});
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic push_item(input logic is_done, input int addr, input logic [3:0] data);
        exp_q.push_back({is_done, 8'(addr), data});
    endtask

    // Bomb write, explosions in walk order, optional clears in the same order, then done.
    task automatic expect_bomb(input int centre, input bit with_clear);
        push_item(1'b0, centre, BOMB);
        foreach (cells[i]) push_item(1'b0, cells[i], EXPLOSION);
        if (with_clear) begin
            foreach (cells[i]) push_item(1'b0, cells[i], NO_BLK);
            push_item(1'b1, 0, 4'd0);
        end
    endtask

    task automatic place(input int r, input int c, input logic with_tick);
        step_clk();
        place_req = 1'b1;
        place_row = 4'(r);
        place_col = 5'(c);
        tick      = with_tick;
        step_clk();
        place_req = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic pulse_tick();
        step_clk();
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
        repeat (2) step_clk();
    endtask

    // which: 0 waits for busy low, 1 waits for exploding high.
    task automatic wait_for(input string name, input int which, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && !busy) || (which == 1 && exploding)) begin
                ok = 1'b1;
                break;
            end
            step_clk();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic run_bomb(input string name, input int r, input int c);
        expect_bomb(r * NUM_COL + c, 1'b1);
        place(r, c, 1'b0);
        repeat (FUSE_T) pulse_tick();
        wait_for({name, "_explode"}, 1, 100);
        repeat (EXPL_T) pulse_tick();
        wait_for({name, "_idle"}, 0, 100);
        step_clk();
    endtask

    initial begin
        for (int i = 0; i < NUM_ROW * NUM_COL; i++) mem[i] = NO_BLK;

        repeat (3) step_clk();
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_exploding", 32'(exploding), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        rst = 1'b0;
        step_clk();

        // Open field at (5,9), with the placement latency checked directly.
        cells = '{104, 105, 106, 103, 102, 123, 142, 85, 66};
        expect_bomb(104, 1'b1);
        place(5, 9, 1'b0);
        check("t1_bomb_latency", {wr_en, 19'b0, wr_addr, wr_data}, {1'b1, 19'b0, 8'd104, 4'(BOMB)});
        check("t1_busy", 32'(busy), 1);
        repeat (FUSE_T) pulse_tick();
        wait_for("t1_explode", 1, 100);
        repeat (EXPL_T) pulse_tick();
        wait_for("t1_idle", 0, 100);
        check("t1_exploding_low", 32'(exploding), 0);
        check("t1_centre_cleared", 32'(mem[104]), 0);

        // Permanent block stops the right arm before its first cell.
        mem[105] = PERM_BLK;
        cells = '{104, 103, 102, 123, 142, 85, 66};
        run_bomb("t2", 5, 9);
        check("t2_perm_kept", 32'(mem[105]), 32'(PERM_BLK));
        mem[105] = NO_BLK;

        // Destroyable block burns and ends the left arm.
        mem[103] = DESTROYABLE_BLK;
        cells = '{104, 105, 106, 103, 123, 142, 85, 66};
        run_bomb("t3", 5, 9);
        check("t3_destroyable_cleared", 32'(mem[103]), 0);

        // Corner: left and up arms are off-grid from the first step.
        cells = '{0, 1, 2, 19, 38};
        run_bomb("t4", 0, 0);

        // Out-of-range placement is ignored.
        base_writes = writes_seen;
        place(11, 0, 1'b0);
        repeat (3) step_clk();
        check("oor_no_write", 32'(writes_seen), 32'(base_writes));
        check("oor_not_busy", 32'(busy), 0);

        // Tick with place_req does not count; requests while busy are dropped.
        cells = '{104, 105, 106, 103, 102, 123, 142, 85, 66};
        expect_bomb(104, 1'b1);
        base_writes = writes_seen;
        place(5, 9, 1'b1);
        repeat (FUSE_T - 1) pulse_tick();
        repeat (10) step_clk();
        check("t5_fuse_not_early", 32'(writes_seen), 32'(base_writes + 1));
        check("t5_not_exploding", 32'(exploding), 0);
        place(2, 2, 1'b0);
        pulse_tick();
        wait_for("t5_explode", 1, 100);
        place(2, 2, 1'b0);
        repeat (EXPL_T) pulse_tick();
        wait_for("t5_idle", 0, 100);
        step_clk();

        // Reset in the middle of the burn, then a fresh bomb.
        expect_bomb(104, 1'b0);
        place(5, 9, 1'b0);
        repeat (FUSE_T) pulse_tick();
        wait_for("t6_explode", 1, 100);
        repeat (3) step_clk();
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_exploding", 32'(exploding), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_pending_before_rst", 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (2) step_clk();
        rst = 1'b0;
        step_clk();
        cells = '{20, 21, 22, 19, 39, 58, 1};
        expect_bomb(20, 1'b1);
        place(1, 1, 1'b0);
        check("t6_bomb_latency", {wr_en, 19'b0, wr_addr, wr_data}, {1'b1, 19'b0, 8'd20, 4'(BOMB)});
        repeat (FUSE_T) pulse_tick();
        wait_for("t6b_explode", 1, 100);
        repeat (EXPL_T) pulse_tick();
        wait_for("t6b_idle", 0, 100);

        repeat (5) step_clk();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
